wb_conbus_rr: RTL and testbench

- Parametrised Wishbone shared-bus interconnect: N masters, M slaves, round-robin arbitration, address decode on the upper address bits.
- Decode ignores adr[31], so the cache-bypass shadow at 0x8xxxxxxx maps onto the same slave as 0x0xxxxxxx.
- Successor to the fixed 5-master/6-slave conbus: adds arbitrary master/slave counts, per-slave decode masks, bus-error on unmapped addresses and an optional slave-timeout error.
- Sits between the CPU I/D buses, JTAG and DMA masters and the RAM, monitor, Ethernet and CSR-bridge slaves.

---
 rtl/wb_conbus_pkg.sv | 21 ++
 rtl/wb_conbus_rr_if.sv | 46 ++++
 rtl/wb_rr_arbiter.sv | 66 ++++++
 rtl/wb_conbus_rr.sv | 146 ++++++++++++++
 tb/tb_wb_conbus_rr.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_conbus_pkg.sv
// Shared Wishbone interconnect types: cycle-type codes, bus widths, shadow bit and arbiter states.
package wb_conbus_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int WB_ADR_W   = 32;
    localparam int WB_DAT_W   = 32;
    // adr[31] selects the cache-bypass alias and never takes part in decode.
    localparam int SHADOW_BIT = 31;

    typedef logic [WB_ADR_W-1:0] wb_adr_t;
    typedef logic [WB_DAT_W-1:0] wb_dat_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_conbus_rr_if.sv
// Bundle of master-side and slave-side Wishbone signals of the shared-bus interconnect.
interface wb_conbus_rr_if
    import wb_conbus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int N_SLAVES  = 6
);
    logic [N_MASTERS*32-1:0] m_adr_i;
    logic [N_MASTERS*32-1:0] m_dat_i;
    logic [N_MASTERS*4-1:0]  m_sel_i;
    logic [N_MASTERS*3-1:0]  m_cti_i;
    logic [N_MASTERS-1:0]    m_we_i;
    logic [N_MASTERS-1:0]    m_cyc_i;
    logic [N_MASTERS-1:0]    m_stb_i;
    wb_dat_t                 m_dat_o;
    logic [N_MASTERS-1:0]    m_ack_o;
    logic [N_MASTERS-1:0]    m_err_o;

    wb_adr_t                 s_adr_o;
    wb_dat_t                 s_dat_o;
    logic [3:0]              s_sel_o;
    logic [2:0]              s_cti_o;
    logic                    s_we_o;
    logic [N_SLAVES-1:0]     s_cyc_o;
    logic [N_SLAVES-1:0]     s_stb_o;
    logic [N_SLAVES*32-1:0]  s_dat_i;
    logic [N_SLAVES-1:0]     s_ack_i;

    modport conbus (
        input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o
    );

    modport slave (
        input  s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after last_grant and holds it until release_i.
module wb_rr_arbiter
    import wb_conbus_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          release_i,
    output logic          grant_valid,
    output logic [IW-1:0] grant
);
    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    logic          pick_found;

    // Scan last_grant+1 .. last_grant+N so the previous owner is considered last.
    always_comb begin
        idx        = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_grant_q) + k) % N);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (state_q == ARB_IDLE || release_i) begin
            if (pick_found) begin
                state_d      = ARB_OWNED;
                grant_d      = pick;
                last_grant_d = pick;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(N - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_valid = (state_q == ARB_OWNED);
    assign grant       = grant_q;

endmodule

// File: rtl/wb_conbus_rr.sv
// Wishbone shared-bus interconnect: round-robin master grant, masked decode on adr[30 -: DECODE_W].
// Define WB_CONBUS_TIMEOUT_EN to raise err on a slave that leaves a strobe unacknowledged too long.
module wb_conbus_rr
    import wb_conbus_pkg::*;
#(
    parameter int                           N_MASTERS      = 4,
    parameter int                           N_SLAVES       = 6,
    parameter int                           DECODE_W       = 3,
    parameter logic [N_SLAVES*DECODE_W-1:0] S_ADDR         = {6{3'b000}},
    parameter logic [N_SLAVES*DECODE_W-1:0] S_MASK         = {6{3'b111}},
    parameter int                           TIMEOUT_CYCLES = 255
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    wb_conbus_rr_if.conbus bus
);
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    logic                grant_valid;
    logic [MW-1:0]       grant;
    logic                cyc_raw;
    logic                g_cyc, g_stb, g_we;
    wb_adr_t             g_adr;
    wb_dat_t             g_dat;
    logic [3:0]          g_sel;
    logic [2:0]          g_cti;
    logic [N_SLAVES-1:0] hit;
    logic [SW-1:0]       sel;
    logic                any_hit;
    logic                ack_sel;
    logic                err_q, err_d;
    logic                to_err;

    assign cyc_raw = bus.m_cyc_i[grant];

    wb_rr_arbiter #(.N(N_MASTERS)) u_arb (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .req         (bus.m_cyc_i),
        .release_i   (~cyc_raw),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_cti = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        if (grant_valid) begin
            g_adr = bus.m_adr_i[int'(grant)*32 +: 32];
            g_dat = bus.m_dat_i[int'(grant)*32 +: 32];
            g_sel = bus.m_sel_i[int'(grant)*4 +: 4];
            g_cti = bus.m_cti_i[int'(grant)*3 +: 3];
            g_we  = bus.m_we_i[grant];
            g_cyc = bus.m_cyc_i[grant];
            g_stb = bus.m_stb_i[grant];
        end
    end

    // Lowest-index hit wins, so overlapping windows still strobe a single slave.
    always_comb begin
        hit     = '0;
        sel     = '0;
        any_hit = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            hit[i] = (((g_adr[SHADOW_BIT-1 -: DECODE_W] ^ S_ADDR[i*DECODE_W +: DECODE_W])
                       & S_MASK[i*DECODE_W +: DECODE_W]) == '0);
        end
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel     = SW'(i);
                any_hit = 1'b1;
            end
        end
        ack_sel = g_cyc & any_hit & bus.s_ack_i[sel];
    end

    always_comb begin
        err_d = g_cyc & g_stb & ~any_hit & ~err_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

`ifdef WB_CONBUS_TIMEOUT_EN
    localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            stall;

    // The terminal cycle itself raises err, so an ack landing on that cycle wins.
    always_comb begin
        stall    = g_cyc & g_stb & any_hit & ~ack_sel;
        to_err   = stall && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        to_cnt_d = '0;
        if (stall && !to_err) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign to_err         = 1'b0;
`endif

    always_comb begin
        bus.s_adr_o = g_adr;
        bus.s_dat_o = g_dat;
        bus.s_sel_o = g_sel;
        bus.s_cti_o = g_cti;
        bus.s_we_o  = g_we;
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        if (any_hit) begin
            bus.s_cyc_o[sel] = g_cyc;
            bus.s_stb_o[sel] = g_stb;
        end
        bus.m_dat_o = (g_cyc && any_hit) ? bus.s_dat_i[int'(sel)*32 +: 32] : '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        if (grant_valid) begin
            bus.m_ack_o[grant] = ack_sel & g_stb;
            bus.m_err_o[grant] = err_q | to_err;
        end
    end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed bench for wb_conbus_rr: 4 masters, 6 slaves, decode values 0,1,2,3,4 and 6/7 (masked).
module tb_wb_conbus_rr;
    import wb_conbus_pkg::*;

    localparam int NM = 4;
    localparam int NS = 6;
`ifdef WB_CONBUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    wb_conbus_rr_if #(.N_MASTERS(NM), .N_SLAVES(NS)) bus ();

    wb_conbus_rr #(
        .N_MASTERS      (NM),
        .N_SLAVES       (NS),
        .DECODE_W       (3),
        .S_ADDR         ({3'b110, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000}),
        .S_MASK         ({3'b110, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111}),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.s_ack_i = '0;
    endtask

    task automatic drive_master(input int m, input logic [31:0] adr, input logic on, input logic [2:0] cti);
        bus.m_adr_i[m*32 +: 32] = adr;
        bus.m_cti_i[m*3 +: 3]   = cti;
        bus.m_cyc_i[m]          = on;
        bus.m_stb_i[m]          = on;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.m_cyc_i = '1;
        bus.m_stb_i = '1;
        bus.s_ack_i = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 6'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected %b", bus.s_cyc_o, 6'b0); end
        checks++; if (bus.s_stb_o !== 6'b0) begin errors++; $display("FAIL reset_s_stb: got %b expected %b", bus.s_stb_o, 6'b0); end
        checks++; if (bus.m_ack_o !== 4'b0) begin errors++; $display("FAIL reset_m_ack: got %b expected %b", bus.m_ack_o, 4'b0); end
        checks++; if (bus.m_err_o !== 4'b0) begin errors++; $display("FAIL reset_m_err: got %b expected %b", bus.m_err_o, 4'b0); end
        checks++; if (bus.s_adr_o !== 32'h0) begin errors++; $display("FAIL reset_s_adr: got %h expected %h", bus.s_adr_o, 32'h0); end
        checks++; if (bus.m_dat_o !== 32'h0) begin errors++; $display("FAIL reset_m_dat: got %h expected %h", bus.m_dat_o, 32'h0); end
        idle_all();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_basic_read();
        logic [5:0] exp_cyc [5] = '{6'b000000, 6'b000001, 6'b000001, 6'b000001, 6'b000000};
        logic [3:0] exp_ack [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive_master(0, 32'h0000_0010, 1'b1, CTI_CLASSIC);
            if (c == 3) bus.s_ack_i[0] = 1'b1;
            if (c == 4) begin
                drive_master(0, 32'h0000_0010, 1'b0, CTI_CLASSIC);
                bus.s_ack_i = '0;
            end
            @(negedge clk);
            checks++; if (bus.s_cyc_o !== exp_cyc[c]) begin errors++; $display("FAIL read_s_cyc c%0d: got %b expected %b", c, bus.s_cyc_o, exp_cyc[c]); end
            checks++; if (bus.m_ack_o !== exp_ack[c]) begin errors++; $display("FAIL read_m_ack c%0d: got %b expected %b", c, bus.m_ack_o, exp_ack[c]); end
            if (c == 3) begin
                checks++; if (bus.m_dat_o !== 32'hD000_0000) begin errors++; $display("FAIL read_m_dat: got %h expected %h", bus.m_dat_o, 32'hD000_0000); end
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] cyc_tbl [9] = '{4'b1011, 4'b1011, 4'b1010, 4'b1011, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0000};
        logic [3:0] exp_ack [9] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        apply_reset();
        drive_master(0, 32'h0000_0100, 1'b0, CTI_CLASSIC);
        drive_master(1, 32'h0000_0104, 1'b0, CTI_CLASSIC);
        drive_master(3, 32'h0000_010C, 1'b0, CTI_CLASSIC);
        bus.s_ack_i[0] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            bus.m_cyc_i = cyc_tbl[c];
            bus.m_stb_i = cyc_tbl[c];
            @(negedge clk);
            checks++; if (bus.m_ack_o !== exp_ack[c]) begin errors++; $display("FAIL rr_m_ack c%0d: got %b expected %b", c, bus.m_ack_o, exp_ack[c]); end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_shadow_and_mask();
        drive_master(1, 32'h9000_0004, 1'b1, CTI_CLASSIC);
        next_cycle();
        bus.s_ack_i[1] = 1'b1;
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 6'b000010) begin errors++; $display("FAIL shadow_s_cyc: got %b expected %b", bus.s_cyc_o, 6'b000010); end
        checks++; if (bus.s_adr_o !== 32'h9000_0004) begin errors++; $display("FAIL shadow_s_adr: got %h expected %h", bus.s_adr_o, 32'h9000_0004); end
        checks++; if (bus.s_dat_o !== 32'hA000_0001) begin errors++; $display("FAIL shadow_s_dat: got %h expected %h", bus.s_dat_o, 32'hA000_0001); end
        checks++; if (bus.m_ack_o !== 4'b0010) begin errors++; $display("FAIL shadow_m_ack: got %b expected %b", bus.m_ack_o, 4'b0010); end
        checks++; if (bus.m_dat_o !== 32'hD000_0001) begin errors++; $display("FAIL shadow_m_dat: got %h expected %h", bus.m_dat_o, 32'hD000_0001); end
        next_cycle();
        drive_master(1, 32'h9000_0004, 1'b0, CTI_CLASSIC);
        bus.s_ack_i = '0;
        next_cycle();
        drive_master(3, 32'h7000_0000, 1'b1, CTI_CLASSIC);
        next_cycle();
        bus.s_ack_i[5] = 1'b1;
        @(negedge clk);
        checks++; if (bus.s_stb_o !== 6'b100000) begin errors++; $display("FAIL mask_s_stb: got %b expected %b", bus.s_stb_o, 6'b100000); end
        checks++; if (bus.m_ack_o !== 4'b1000) begin errors++; $display("FAIL mask_m_ack: got %b expected %b", bus.m_ack_o, 4'b1000); end
        next_cycle();
        idle_all();
        next_cycle();
    endtask

    task automatic test_unmapped();
        logic [3:0] exp_err [5] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        bus.s_ack_i = '1;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive_master(2, 32'h5000_0000, 1'b1, CTI_CLASSIC);
            if (c == 3) drive_master(2, 32'h5000_0000, 1'b0, CTI_CLASSIC);
            @(negedge clk);
            checks++; if (bus.m_err_o !== exp_err[c]) begin errors++; $display("FAIL unmapped_m_err c%0d: got %b expected %b", c, bus.m_err_o, exp_err[c]); end
            checks++; if (bus.s_cyc_o !== 6'b0) begin errors++; $display("FAIL unmapped_s_cyc c%0d: got %b expected %b", c, bus.s_cyc_o, 6'b0); end
            checks++; if (bus.m_ack_o !== 4'b0) begin errors++; $display("FAIL unmapped_m_ack c%0d: got %b expected %b", c, bus.m_ack_o, 4'b0); end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_timeout();
        logic [3:0] exp_err;
        for (int c = 0; c < 18; c++) begin
            if (c == 0) drive_master(0, 32'h3000_0000, 1'b1, CTI_CLASSIC);
            if (c == 17) drive_master(0, 32'h3000_0000, 1'b0, CTI_CLASSIC);
            @(negedge clk);
            exp_err = (TO_EN && c == 16) ? 4'b0001 : 4'b0000;
            checks++; if (bus.m_err_o !== exp_err) begin errors++; $display("FAIL timeout_m_err c%0d: got %b expected %b", c, bus.m_err_o, exp_err); end
            next_cycle();
        end
        for (int c = 0; c < 18; c++) begin
            if (c == 0) drive_master(0, 32'h3000_0000, 1'b1, CTI_CLASSIC);
            if (c == 16) bus.s_ack_i[3] = 1'b1;
            if (c == 17) begin
                drive_master(0, 32'h3000_0000, 1'b0, CTI_CLASSIC);
                bus.s_ack_i = '0;
            end
            @(negedge clk);
            checks++; if (bus.m_err_o !== 4'b0) begin errors++; $display("FAIL timeout_ack_m_err c%0d: got %b expected %b", c, bus.m_err_o, 4'b0); end
            if (c == 16) begin
                checks++; if (bus.m_ack_o !== 4'b0001) begin errors++; $display("FAIL timeout_ack_m_ack: got %b expected %b", bus.m_ack_o, 4'b0001); end
            end
            next_cycle();
        end
        idle_all();
        next_cycle();
    endtask

    task automatic test_burst_reset();
        drive_master(0, 32'h0000_0200, 1'b1, CTI_INCR);
        bus.s_ack_i[0] = 1'b1;
        next_cycle();
        drive_master(1, 32'h0000_0300, 1'b1, CTI_CLASSIC);
        @(negedge clk);
        checks++; if (bus.s_cti_o !== CTI_INCR) begin errors++; $display("FAIL burst_s_cti: got %b expected %b", bus.s_cti_o, CTI_INCR); end
        checks++; if (bus.m_ack_o !== 4'b0001) begin errors++; $display("FAIL burst_beat1: got %b expected %b", bus.m_ack_o, 4'b0001); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.m_ack_o !== 4'b0001) begin errors++; $display("FAIL burst_beat2: got %b expected %b", bus.m_ack_o, 4'b0001); end
        checks++; if (bus.s_adr_o !== 32'h0000_0200) begin errors++; $display("FAIL burst_hold_adr: got %h expected %h", bus.s_adr_o, 32'h0000_0200); end
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.s_cyc_o !== 6'b0) begin errors++; $display("FAIL burst_rst_s_cyc: got %b expected %b", bus.s_cyc_o, 6'b0); end
        checks++; if (bus.s_stb_o !== 6'b0) begin errors++; $display("FAIL burst_rst_s_stb: got %b expected %b", bus.s_stb_o, 6'b0); end
        checks++; if (bus.m_ack_o !== 4'b0) begin errors++; $display("FAIL burst_rst_m_ack: got %b expected %b", bus.m_ack_o, 4'b0); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (bus.m_ack_o !== 4'b0001) begin errors++; $display("FAIL burst_after_rst_m_ack: got %b expected %b", bus.m_ack_o, 4'b0001); end
        checks++; if (bus.s_adr_o !== 32'h0000_0200) begin errors++; $display("FAIL burst_after_rst_s_adr: got %h expected %h", bus.s_adr_o, 32'h0000_0200); end
        next_cycle();
        idle_all();
        repeat (2) next_cycle();
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.m_adr_i = '0;
        bus.m_sel_i = '1;
        bus.m_cti_i = '0;
        bus.m_we_i  = '0;
        idle_all();
        for (int m = 0; m < NM; m++) bus.m_dat_i[m*32 +: 32] = 32'hA000_0000 | 32'(m);
        for (int s = 0; s < NS; s++) bus.s_dat_i[s*32 +: 32] = 32'hD000_0000 | 32'(s);

        test_reset();
        test_basic_read();
        test_round_robin();
        test_shadow_and_mask();
        test_unmapped();
        test_timeout();
        test_burst_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
